// File: rtl/mac_tx_arbiter_pkg.sv
// mac_tx_arbiter_pkg
//   Shared definitions for the MAC transmit arbiter slice: default flit
//   geometry, the flit field order (data, keep, last) and the arbiter
//   state constants.
package mac_tx_arbiter_pkg;

  localparam int FLIT_DATA_W = 64;
  localparam int FLIT_KEEP_W = FLIT_DATA_W / 8;

  // Canonical flit field order, most significant field first.
  typedef struct packed {
    logic [FLIT_DATA_W-1:0] data;
    logic [FLIT_KEEP_W-1:0] keep;
    logic                   last;
  } flit_t;

  // Arbiter states: IDLE, FWD, ABORT, DROP, GAP.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FWD   = 3'd1;
  localparam logic [2:0] ST_ABORT = 3'd2;
  localparam logic [2:0] ST_DROP  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

endpackage

// File: rtl/mac_tx_arbiter_if.sv
// mac_tx_arbiter_if
//   Flit bus between the NUM_PORTS requesters and the single MAC TX stream.
//   Signals:
//     in_valid/in_ready/in_last : per-port handshake and end-of-packet
//     in_data/in_keep           : port p at [p*DATA_W +: DATA_W] / [p*KEEP_W +: KEEP_W]
//     out_valid/out_ready       : handshake towards the MAC
//     out_data/out_keep/out_last: forwarded flit
//     out_abort                 : qualifies out_last, MAC must discard the packet
//   Modports: master = requesters + MAC side (testbench), slave = arbiter.
interface mac_tx_arbiter_if
  import mac_tx_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = FLIT_DATA_W
);
  localparam int KEEP_W = DATA_W / 8;

  logic [NUM_PORTS-1:0]        in_valid;
  logic [NUM_PORTS-1:0]        in_ready;
  logic [NUM_PORTS-1:0]        in_last;
  logic [NUM_PORTS*DATA_W-1:0] in_data;
  logic [NUM_PORTS*KEEP_W-1:0] in_keep;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [KEEP_W-1:0] out_keep;
  logic              out_last;
  logic              out_abort;

  modport master (
    output in_valid, in_last, in_data, in_keep, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last, out_abort
  );

  modport slave (
    input  in_valid, in_last, in_data, in_keep, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last, out_abort
  );

endinterface

// File: rtl/mac_tx_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker, shared with the RX side.
//   Ports:
//     req       in  NUM_PORTS  request vector
//     ptr       in  IDX_W      index of the previous winner (lowest priority)
//     grant     out NUM_PORTS  one-hot grant, all zero when nothing requests
//     grant_idx out IDX_W      index of the granted port
module rr_arbiter #(
  parameter  int NUM_PORTS = 4,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx
);

  // Scan from the farthest position back towards ptr+1 so that the last hit,
  // which overwrites earlier ones, is the nearest requester after ptr.
  always_comb begin
    int p;
    grant     = '0;
    grant_idx = '0;
    p         = 0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      p = (int'(ptr) + i) % NUM_PORTS;
      if (req[p]) begin
        grant     = '0;
        grant[p]  = 1'b1;
        grant_idx = p[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter
//   Packet-granular round-robin arbiter sharing the 10G MAC TX stream.
//   A granted port owns the MAC until in_last; a stall watchdog aborts a
//   packet whose source stops supplying flits, then drains its remainder.
//   Ports:
//     clk, rst_n   clock and asynchronous active-low reset
//     bus          flit bus (slave side), see mac_tx_arbiter_if
//     out_port     index of the current/last grant
//     busy         high whenever the arbiter is not idle
//     abort_count  saturating count of watchdog aborts
module mac_tx_arbiter
  import mac_tx_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS     = 4,
  parameter  int DATA_W        = FLIT_DATA_W,
  parameter  int IPG_CYCLES    = 1,
  parameter  int STALL_TIMEOUT = 1024,
  localparam int KEEP_W        = DATA_W / 8,
  localparam int IDX_W         = $clog2(NUM_PORTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mac_tx_arbiter_if.slave       bus,
  output logic [IDX_W-1:0]      out_port,
  output logic                  busy,
  output logic [15:0]           abort_count
);

  localparam int STALL_W  = ($clog2(STALL_TIMEOUT + 1) < 1) ? 1 : $clog2(STALL_TIMEOUT + 1);
  localparam int GAP_W    = ($clog2(IPG_CYCLES + 1) < 1) ? 1 : $clog2(IPG_CYCLES + 1);
  localparam int GAP_LAST = (IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0;
  // Where a finished (or drained) packet goes next.
  localparam logic [2:0] ST_END = (IPG_CYCLES == 0) ? ST_IDLE : ST_GAP;

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   port_q, port_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [15:0]        abort_cnt_q, abort_cnt_d;

  logic [NUM_PORTS-1:0] gnt_onehot;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 sel_valid;
  logic                 sel_last;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .req       (bus.in_valid),
    .ptr       (ptr_q),
    .grant     (gnt_onehot),
    .grant_idx (gnt_idx)
  );

  assign sel_valid   = bus.in_valid[port_q];
  assign sel_last    = bus.in_last[port_q];
  assign out_port    = port_q;
  assign busy        = (state_q != ST_IDLE);
  assign abort_count = abort_cnt_q;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    port_d        = port_q;
    stall_d       = stall_q;
    gap_d         = gap_q;
    abort_cnt_d   = abort_cnt_q;
    bus.in_ready  = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_keep  = '0;
    bus.out_last  = 1'b0;
    bus.out_abort = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Counters restart for every packet; the winner becomes the new
        // lowest-priority port for the following arbitration.
        stall_d = '0;
        gap_d   = '0;
        if (|gnt_onehot) begin
          ptr_d   = gnt_idx;
          port_d  = gnt_idx;
          state_d = ST_FWD;
        end
      end

      ST_FWD: begin
        bus.out_valid        = sel_valid;
        bus.out_data         = bus.in_data[port_q*DATA_W +: DATA_W];
        bus.out_keep         = bus.in_keep[port_q*KEEP_W +: KEEP_W];
        bus.out_last         = sel_last;
        bus.in_ready[port_q] = bus.out_ready;
        // Only a silent source counts as a stall; MAC backpressure holds.
        if (sel_valid && bus.out_ready) begin
          stall_d = '0;
          if (sel_last) state_d = ST_END;
        end else if (!sel_valid && (STALL_TIMEOUT != 0)) begin
          stall_d = stall_q + STALL_W'(1);
          if (stall_d == STALL_W'(STALL_TIMEOUT)) state_d = ST_ABORT;
        end
      end

      ST_ABORT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = 1'b1;
        bus.out_abort = 1'b1;
        if (bus.out_ready) begin
          if (abort_cnt_q != 16'hFFFF) abort_cnt_d = abort_cnt_q + 16'd1;
          state_d = ST_DROP;
        end
      end

      ST_DROP: begin
        // Swallow the rest of the aborted packet so the source can move on.
        bus.in_ready[port_q] = 1'b1;
        if (sel_valid && sel_last) state_d = ST_END;
      end

      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) state_d = ST_IDLE;
        else                           gap_d   = gap_q + GAP_W'(1);
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Pointer resets to the last port so port 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IDX_W'(NUM_PORTS - 1);
      port_q      <= '0;
      stall_q     <= '0;
      gap_q       <= '0;
      abort_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      port_q      <= port_d;
      stall_q     <= stall_d;
      gap_q       <= gap_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb_mac_tx_arbiter
//   Self-checking bench: per-port packet queues feed the arbiter, a
//   packet-level model predicts every output each cycle, and directed
//   scenarios pin the model with hand-computed values.
module tb_mac_tx_arbiter;

  localparam int NP  = 4;
  localparam int DW  = 64;
  localparam int KW  = 8;
  localparam int IPG = 1;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mac_tx_arbiter_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();
  mac_tx_arbiter_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus_z ();

  logic [1:0]  out_port, out_port_z;
  logic        busy, busy_z;
  logic [15:0] abort_count, abort_count_z;

  mac_tx_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .IPG_CYCLES(IPG), .STALL_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .out_port(out_port), .busy(busy), .abort_count(abort_count)
  );

  // Second instance: no inter-packet gap, watchdog disabled.
  mac_tx_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .IPG_CYCLES(0), .STALL_TIMEOUT(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .bus(bus_z.slave),
    .out_port(out_port_z), .busy(busy_z), .abort_count(abort_count_z)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    int            pre;
  } tb_flit_t;

  typedef enum {M_SEND, M_ABORT, M_DROP} mmode_e;

  tb_flit_t src_q [NP][$];
  int       waited [NP];
  int       valid_pct, ready_pct, ready_hold;

  int     m_owner, m_last, m_gap, m_stall, m_port, m_aborts;
  mmode_e m_mode;
  bit     prev_busy;

  int n_checks = 0;
  int n_errors = 0;

  int   tcyc, obs_xfers;
  logic obs_valid [64];
  logic obs_busy  [64];
  logic obs_last  [64];
  logic obs_abort [64];
  logic [1:0]    obs_port [64];
  logic [KW-1:0] obs_keep [64];
  logic [DW-1:0] obs_data [64];
  int   grant_log [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_owner = -1; m_last = NP - 1; m_gap = 0; m_stall = 0;
    m_port = 0; m_aborts = 0; m_mode = M_SEND; prev_busy = 1'b0;
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      waited[p] = 0;
    end
    ready_hold = 0;
  endtask

  task automatic markTest();
    tcyc = 0; obs_xfers = 0;
    grant_log.delete();
  endtask

  task automatic pushFlit(input int p, input logic [DW-1:0] d, input logic [KW-1:0] k,
                          input logic l, input int pre);
    tb_flit_t f;
    f.data = d; f.keep = k; f.last = l; f.pre = pre;
    src_q[p].push_back(f);
  endtask

  task automatic pushPkt(input int p, input int len, input int first_pre, input bit allow_stall);
    int pre, r;
    for (int i = 0; i < len; i++) begin
      pre = first_pre;
      if (i > 0) begin
        r = int'($urandom_range(99));
        if (allow_stall && r < 3)  pre = 17 + int'($urandom_range(7));
        else if (r < 10)           pre = 1 + int'($urandom_range(3));
        else                       pre = 0;
      end
      pushFlit(p, {$urandom, $urandom}, 8'($urandom), (i == len - 1), pre);
    end
  endtask

  task automatic popFlit(input int p);
    void'(src_q[p].pop_front());
    waited[p] = 0;
  endtask

  function automatic bit allIdle();
    bit e = (m_owner < 0) && (m_gap == 0);
    for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) e = 1'b0;
    return e;
  endfunction

  // Drive each port from the head of its queue, honouring the per-flit
  // silent period before it is offered.
  task automatic applyStimulus();
    logic [NP-1:0]    v, l;
    logic [NP*DW-1:0] d;
    logic [NP*KW-1:0] k;
    v = '0; l = '0; d = '0; k = '0;
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0) begin
        d[p*DW +: DW] = src_q[p][0].data;
        k[p*KW +: KW] = src_q[p][0].keep;
        l[p]          = src_q[p][0].last;
        if (waited[p] < src_q[p][0].pre) waited[p]++;
        else v[p] = (int'($urandom_range(99)) < valid_pct);
      end
    end
    bus.in_valid = v; bus.in_last = l; bus.in_data = d; bus.in_keep = k;
    if (ready_hold > 0) begin
      bus.out_ready = 1'b0;
      ready_hold--;
    end else begin
      bus.out_ready = (int'($urandom_range(99)) < ready_pct);
    end
  endtask

  // Compare every output with the packet-level model, then advance the model
  // across the coming clock edge.
  task automatic checkOutput();
    logic [NP-1:0] iv, il, e_ready;
    logic          e_valid, e_last, e_abort, e_busy;
    logic [DW-1:0] e_data;
    logic [KW-1:0] e_keep;
    int g, p;
    bit found;
    iv = bus.in_valid; il = bus.in_last;
    e_valid = 1'b0; e_last = 1'b0; e_abort = 1'b0; e_data = '0; e_keep = '0; e_ready = '0;
    e_busy = (m_owner >= 0) || (m_gap > 0);
    g = (m_owner >= 0) ? m_owner : 0;
    if (m_owner >= 0) begin
      if (m_mode == M_SEND) begin
        e_valid = iv[g];
        e_data  = bus.in_data[g*DW +: DW];
        e_keep  = bus.in_keep[g*KW +: KW];
        e_last  = il[g];
        e_ready[g] = bus.out_ready;
      end else if (m_mode == M_ABORT) begin
        e_valid = 1'b1; e_last = 1'b1; e_abort = 1'b1;
      end else begin
        e_ready[g] = 1'b1;
      end
    end

    chk("out_valid", bus.out_valid, e_valid);
    if (e_valid) begin
      chk("out_data", bus.out_data, e_data);
      chk("out_keep", bus.out_keep, e_keep);
      chk("out_last", bus.out_last, e_last);
      chk("out_abort", bus.out_abort, e_abort);
    end
    chk("in_ready", bus.in_ready, e_ready);
    chk("out_port", out_port, m_port);
    chk("busy", busy, e_busy);
    chk("abort_count", abort_count, m_aborts);

    if (tcyc < 64) begin
      obs_valid[tcyc] = bus.out_valid; obs_busy[tcyc] = busy;
      obs_last[tcyc]  = bus.out_last;  obs_abort[tcyc] = bus.out_abort;
      obs_port[tcyc]  = out_port;      obs_keep[tcyc]  = bus.out_keep;
      obs_data[tcyc]  = bus.out_data;
    end
    tcyc++;
    if (bus.out_valid && bus.out_ready && !bus.out_abort) obs_xfers++;
    if (busy && !prev_busy) grant_log.push_back(int'(out_port));
    prev_busy = busy;

    if (m_owner < 0 && m_gap == 0) begin
      found = 1'b0;
      for (int i = 1; i <= NP; i++) begin
        p = (m_last + i) % NP;
        if (!found && iv[p]) begin
          found = 1'b1; m_owner = p; m_last = p; m_port = p;
          m_mode = M_SEND; m_stall = 0;
        end
      end
    end else if (m_owner < 0) begin
      m_gap--;
    end else if (m_mode == M_SEND) begin
      if (iv[g] && bus.out_ready) begin
        popFlit(g); m_stall = 0;
        if (il[g]) begin m_owner = -1; m_gap = IPG; end
      end else if (!iv[g]) begin
        m_stall++;
        if (m_stall == TO) m_mode = M_ABORT;
      end
    end else if (m_mode == M_ABORT) begin
      if (bus.out_ready) begin
        if (m_aborts < 65535) m_aborts++;
        m_mode = M_DROP;
      end
    end else begin
      if (iv[g]) begin
        popFlit(g);
        if (il[g]) begin m_owner = -1; m_gap = IPG; end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    applyStimulus();
    #1;
    checkOutput();
  endtask

  task automatic runUntilIdle(input int max_cycles, input string name);
    int n = 0;
    while (!allIdle() && n < max_cycles) begin
      step();
      n++;
    end
    n_checks++;
    if (!allIdle()) begin
      n_errors++;
      $display("[TB] FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  initial begin
    bus.in_valid = '0; bus.in_last = '0; bus.in_data = '0; bus.in_keep = '0; bus.out_ready = 1'b0;
    bus_z.in_valid = '0; bus_z.in_last = '0; bus_z.in_data = '0; bus_z.in_keep = '0;
    bus_z.out_ready = 1'b0;
    valid_pct = 100; ready_pct = 100;
    modelReset();
    markTest();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_port", out_port, 0);
    chk("rst_abort_count", abort_count, 0);
    @(negedge clk) rst_n = 1'b1;

    // Fairness: every port keeps 2-flit packets queued.
    $display("[TB] fairness");
    markTest();
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < NP; p++) pushPkt(p, 2, 0, 1'b0);
    runUntilIdle(500, "fair");
    chk("fair_grants", grant_log.size(), 12);
    for (int i = 0; i < grant_log.size() && i < 12; i++) chk("fair_order", grant_log[i], i % 4);

    // Single packet on port 2.
    $display("[TB] single packet");
    markTest();
    pushFlit(2, 64'h1111_2222_3333_4444, 8'hFF, 1'b0, 0);
    pushFlit(2, 64'h5555_6666_7777_8888, 8'hFF, 1'b0, 0);
    pushFlit(2, 64'h9999_AAAA_BBBB_CCCC, 8'h0F, 1'b1, 0);
    runUntilIdle(50, "single");
    repeat (2) step();
    chk("single_arb_valid", obs_valid[0], 0);
    chk("single_port", obs_port[1], 2);
    chk("single_d0", obs_data[1], 64'h1111_2222_3333_4444);
    chk("single_d1", obs_data[2], 64'h5555_6666_7777_8888);
    chk("single_d2", obs_data[3], 64'h9999_AAAA_BBBB_CCCC);
    chk("single_mid_last", obs_last[2], 0);
    chk("single_last", obs_last[3], 1);
    chk("single_keep", obs_keep[3], 8'h0F);
    chk("single_gap_valid", obs_valid[4], 0);
    chk("single_gap_busy", obs_busy[4], 1);
    chk("single_idle_busy", obs_busy[5], 0);

    // Backpressure: MAC holds ready low for 2000 cycles, then toggles.
    $display("[TB] backpressure");
    markTest();
    for (int i = 0; i < 4; i++) pushFlit(1, {$urandom, $urandom}, 8'hFF, (i == 3), 0);
    ready_hold = 2000; ready_pct = 50;
    runUntilIdle(2300, "bp");
    repeat (2) step();
    chk("bp_held_valid", obs_valid[63], 1);
    chk("bp_held_port", obs_port[63], 1);
    chk("bp_flits", obs_xfers, 4);
    chk("bp_no_abort", abort_count, 0);

    // Watchdog: flit, 20 silent cycles, then the last two flits.
    $display("[TB] watchdog");
    markTest();
    ready_pct = 100;
    pushFlit(0, 64'hAAAA_0000_0000_0001, 8'hFF, 1'b0, 0);
    pushFlit(0, 64'hAAAA_0000_0000_0002, 8'hFF, 1'b0, 20);
    pushFlit(0, 64'hAAAA_0000_0000_0003, 8'hFF, 1'b1, 0);
    runUntilIdle(100, "wd");
    repeat (2) step();
    chk("wd_first_flit", obs_data[1], 64'hAAAA_0000_0000_0001);
    chk("wd_pre_abort_valid", obs_valid[17], 0);
    chk("wd_pre_abort_busy", obs_busy[17], 1);
    chk("wd_abort_valid", obs_valid[18], 1);
    chk("wd_abort_flag", obs_abort[18], 1);
    chk("wd_abort_last", obs_last[18], 1);
    chk("wd_abort_keep", obs_keep[18], 0);
    chk("wd_drop_not_fwd", obs_valid[22], 0);
    chk("wd_gap_busy", obs_busy[24], 1);
    chk("wd_idle_busy", obs_busy[25], 0);
    chk("wd_fwd_count", obs_xfers, 1);
    chk("wd_abort_count", abort_count, 1);

    // Randomized traffic on all ports.
    $display("[TB] random traffic");
    markTest();
    valid_pct = 80; ready_pct = 70;
    for (int i = 0; i < 40; i++)
      for (int p = 0; p < NP; p++)
        if ($urandom_range(3) != 0) pushPkt(p, 1 + int'($urandom_range(4)), int'($urandom_range(3)), 1'b1);
    runUntilIdle(20000, "rand");
    repeat (2) step();

    // Asynchronous reset in the middle of a port 2 packet.
    $display("[TB] async reset");
    markTest();
    valid_pct = 100; ready_pct = 100;
    for (int i = 0; i < 10; i++) pushFlit(2, {$urandom, $urandom}, 8'hFF, (i == 9), 0);
    repeat (3) step();
    chk("ar_before_port", out_port, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", bus.out_valid, 0);
    chk("ar_in_ready", bus.in_ready, 0);
    chk("ar_busy", busy, 0);
    chk("ar_out_port", out_port, 0);
    modelReset();
    bus.in_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    markTest();
    for (int p = NP - 1; p >= 0; p--) pushFlit(p, {$urandom, $urandom}, 8'hFF, 1'b1, 0);
    runUntilIdle(100, "ar");
    chk("ar_first_valid", obs_valid[1], 1);
    chk("ar_first_port", obs_port[1], 0);

    // IPG=0 instance: ports 0 and 3 alternate single-flit packets.
    $display("[TB] zero gap");
    @(posedge clk);
    #1;
    bus_z.in_valid = 4'b1001; bus_z.in_last = 4'b1001; bus_z.in_keep = '1;
    bus_z.in_data = '0;
    bus_z.in_data[0*DW +: DW] = 64'hA0A0_A0A0_A0A0_A0A0;
    bus_z.in_data[3*DW +: DW] = 64'h3B3B_3B3B_3B3B_3B3B;
    bus_z.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) #1;
      else begin
        @(posedge clk);
        #2;
      end
      if (k % 2 == 0) begin
        chk("z_arb_valid", bus_z.out_valid, 0);
        chk("z_arb_busy", busy_z, 0);
        chk("z_arb_ready", bus_z.in_ready, 0);
      end else begin
        chk("z_valid", bus_z.out_valid, 1);
        chk("z_last", bus_z.out_last, 1);
        chk("z_port", out_port_z, (k % 4 == 1) ? 0 : 3);
        chk("z_ready", bus_z.in_ready, (k % 4 == 1) ? 4'b0001 : 4'b1000);
        chk("z_data", bus_z.out_data,
            (k % 4 == 1) ? 64'hA0A0_A0A0_A0A0_A0A0 : 64'h3B3B_3B3B_3B3B_3B3B);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mac_tx_arbiter.md
Name: mac_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single 10G MAC transmit stream between NUM_PORTS requesters (host bridge, loopback, diagnostic generators), in the 156.25 MHz XGMII clock domain, ahead of the MAC TX input.
- Once granted, a port owns the MAC until its packet ends.
- Supports a configurable inter-packet gap and a stall watchdog that aborts a packet whose source stops supplying flits.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8).
- DATA_W, 64, flit data width; KEEP_W = DATA_W/8.
- IPG_CYCLES, 1, idle cycles forced between packets (0 allowed).
- STALL_TIMEOUT, 1024, cycles a granted port may hold in_valid low mid-packet before abort (0 disables the watchdog).

Ports:
- clk  in  1  156.25 MHz MAC clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  NUM_PORTS  per-port flit valid
- in_ready  out  NUM_PORTS  per-port flit accept
- in_data  in  NUM_PORTS*DATA_W  port p at bits [p*DATA_W +: DATA_W]
- in_keep  in  NUM_PORTS*KEEP_W  byte enables, same packing
- in_last  in  NUM_PORTS  end-of-packet flit
- out_valid  out  1  flit to MAC
- out_ready  in  1  MAC accept
- out_data  out  DATA_W  flit data
- out_keep  out  KEEP_W  byte enables
- out_last  out  1  end of packet
- out_abort  out  1  qualifies out_last: the packet is bad and the MAC must discard it
- out_port  out  clog2(NUM_PORTS)  current grant index
- busy  out  1  high in any state other than IDLE
- abort_count  out  16  saturating count of watchdog aborts

Behaviour:
- Reset (async assert, sync deassert by the caller):
  - State is IDLE and the RR pointer is NUM_PORTS-1, so port 0 has first priority.
  - All outputs are 0 and the counters are 0.
- A transfer happens on any cycle where valid and ready are both high.
- States are IDLE, FWD, ABORT, DROP, GAP.
- IDLE:
  - in_ready is all 0 and out_valid is 0.
  - If any in_valid is high, grant the first valid port searching from pointer+1 with wrap-around.
  - Register the grant into out_port and set pointer to the grant.
  - Go to FWD next cycle, so arbitration latency is 1 cycle.
- FWD: zero-latency pass-through from granted port g.
  - out_valid = in_valid[g]; out_data, out_keep and out_last come from g.
  - in_ready[g] = out_ready; every other in_ready is 0; out_abort = 0.
  - A transfer with in_last[g] goes to GAP, or to IDLE if IPG_CYCLES = 0.
  - A single-flit packet (in_last on the first flit) is legal.
- Watchdog, in FWD only:
  - The stall counter clears on every transfer.
  - It increments while in_valid[g] = 0.
  - It holds while in_valid[g] = 1 and out_ready = 0, because MAC backpressure is not a stall.
  - When it reaches STALL_TIMEOUT, go to ABORT.
  - The counter is clog2(STALL_TIMEOUT+1) bits wide.
- ABORT:
  - Drive out_valid=1, out_last=1, out_abort=1, out_keep=0, out_data=0; in_ready all 0.
  - Hold until out_ready.
  - On the transfer, increment abort_count (saturating at 16'hFFFF) and go to DROP.
- DROP:
  - in_ready[g] = 1 and out_valid = 0; flits from g are discarded.
  - A discarded flit with in_last goes to GAP (or IDLE).
  - There is no timeout in DROP.
- GAP:
  - Count IPG_CYCLES cycles with out_valid=0 and in_ready=0, then go to IDLE.
  - The re-arbitration cycle in IDLE is in addition to the gap.
- Fairness: a port that just finished has lowest priority in the next arbitration.
- A grant never changes mid-packet; in_valid on other ports is ignored until IDLE.
- Reset mid-packet: outputs drop immediately and the MAC sees a truncated packet.

Decomposition:
- Shared package (tinsel-wide eth package):
  - DATA_W and KEEP_W.
  - The flit field order.
  - The state enum {IDLE, FWD, ABORT, DROP, GAP}.
- Sub-module rr_arbiter (NUM_PORTS):
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and index.
  - Combinational; reusable for the RX side.

Test Plan:
- Single packet:
  - Stimulus: port 2 sends 3 flits (keep 8'hFF, 8'hFF, 8'h0F), out_ready=1.
  - Response: out_port=2 one cycle after in_valid; 3 flits out back-to-back with matching data; then IPG (1 cycle) and IDLE.
- Fairness:
  - Stimulus: all 4 ports continuously send 2-flit packets.
  - Response: grant order is 0,1,2,3,0,1,...; no port receives two consecutive grants.
- Backpressure:
  - Stimulus: port 1 sends 4 flits while out_ready toggles 1,0,0,1,...
  - Response: no flit is lost or duplicated; in_ready[1] mirrors out_ready; the watchdog does not fire even when out_ready is held low for 2000 cycles.
- Watchdog:
  - Stimulus: STALL_TIMEOUT=16; port 0 sends 1 flit, then drops in_valid for 20 cycles, then sends 2 flits, the last with in_last.
  - Response: after 16 stalled cycles one flit with out_abort=1, out_last=1, keep=0; abort_count=1; the 2 late flits are consumed and not forwarded; then GAP.
- IPG=0 and single-flit packets:
  - Stimulus: ports 0 and 3 alternate 1-flit packets.
  - Response: each packet is followed by exactly one IDLE (arbitration) cycle; out_last=1 on every flit.
- Async reset:
  - Stimulus: assert rst_n low mid-packet on port 2.
  - Response: out_valid, in_ready, busy and out_port go to 0 immediately; after release, port 0 is granted first.
